// File: rtl/fetch_pkg.sv
// Shared fetch-side types: FSM encoding, reset PC and word-alignment helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        VALID = 2'd1,
        ERR   = 2'd2,
        BOOT  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    function automatic logic is_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_unit.sv
// Architectural PC register and instruction-fetch front end.
// Fetches at pc via req/ack, hands {pc, instr} to decode via valid/ready.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      npc,
    input  logic             instr_ready,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      pc,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic             addr_err,
    output logic [CNT_W-1:0] retired
);

    fetch_state_t state;
    fetch_state_t state_n;
    logic         accept;
    logic         load_instr;

    // BOOT keeps imem_req low while reset is held; it leaves on the first edge.
    always_comb begin
        state_n    = state;
        accept     = 1'b0;
        load_instr = 1'b0;
        unique case (state)
            BOOT: state_n = REQ;
            REQ: begin
                if (imem_ack) begin
                    load_instr = 1'b1;
                    state_n    = VALID;
                end
            end
            VALID: begin
                if (instr_ready) begin
                    accept  = 1'b1;
                    state_n = is_aligned(npc) ? REQ : ERR;
                end
            end
            ERR: state_n = ERR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            instr    <= 32'h0;
            addr_err <= 1'b0;
            retired  <= '0;
        end else begin
            state <= state_n;
            if (load_instr) begin
                instr <= imem_rdata;
            end
            if (accept) begin
                pc      <= npc;
                retired <= retired + CNT_W'(1);
                if (!is_aligned(npc)) begin
                    addr_err <= 1'b1;
                end
            end
        end
    end

    assign imem_req    = (state == REQ);
    assign instr_valid = (state == VALID);
    assign imem_addr   = pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a transaction-level reference model.
module tb_pc_fetch_unit;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   npc;
    logic          instr_ready;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic          instr_valid;
    logic          addr_err;
    logic [CW-1:0] retired;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit #(.CNT_W(CW)) dut (
        .clk(clk),
        .reset(reset),
        .npc(npc),
        .instr_ready(instr_ready),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .pc(pc),
        .instr(instr),
        .instr_valid(instr_valid),
        .addr_err(addr_err),
        .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: a fetch is either outstanding, delivered and waiting for
    // decode, or the unit is dead after a misaligned target.
    logic        m_started;
    logic        m_outstanding;
    logic        m_dead;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    int unsigned m_count;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_started     <= 1'b0;
            m_outstanding <= 1'b0;
            m_dead        <= 1'b0;
            m_pc          <= 32'h0000_3000;
            m_instr       <= 32'h0;
            m_count       <= 0;
        end else if (!m_started) begin
            m_started     <= 1'b1;
            m_outstanding <= 1'b1;
        end else if (!m_dead) begin
            if (m_outstanding) begin
                if (imem_ack) begin
                    m_instr       <= imem_rdata;
                    m_outstanding <= 1'b0;
                end
            end else if (instr_ready) begin
                m_pc    <= npc;
                m_count <= m_count + 1;
                if (npc % 4 != 0) m_dead <= 1'b1;
                else m_outstanding <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic e_req, e_val;
        e_req = m_started && !m_dead && m_outstanding;
        e_val = m_started && !m_dead && !m_outstanding;
        chk("m_req", {31'b0, imem_req}, {31'b0, e_req});
        chk("m_valid", {31'b0, instr_valid}, {31'b0, e_val});
        chk("m_err", {31'b0, addr_err}, {31'b0, m_dead});
        chk("m_pc", pc, m_pc);
        chk("m_addr", imem_addr, m_pc);
        chk("m_instr", instr, m_instr);
        chk("m_retired", {29'b0, retired}, m_count % (1 << CW));
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b0;
        npc         = 32'h0;
        instr_ready = 1'b0;
        imem_ack    = 1'b1;
        imem_rdata  = 32'h1111_1111;
        step();
        step();
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_ret", {29'b0, retired}, 32'h0);

        reset      = 1'b1;
        imem_rdata = 32'h3408_0001;
        step();
        chk("c1_req", {31'b0, imem_req}, 32'h1);
        chk("c1_addr", imem_addr, 32'h0000_3000);
        step();
        chk("c2_valid", {31'b0, instr_valid}, 32'h1);
        chk("c2_instr", instr, 32'h3408_0001);
        chk("c2_pc", pc, 32'h0000_3000);

        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        npc         = 32'h0000_3004;
        step();
        chk("acc_pc", pc, 32'h0000_3004);
        chk("acc_req", {31'b0, imem_req}, 32'h1);
        chk("acc_ret", {29'b0, retired}, 32'h1);

        for (int i = 0; i < 3; i++) begin
            imem_ack    = 1'b1;
            instr_ready = 1'b0;
            imem_rdata  = 32'h2000_0000 + i;
            step();
            imem_ack    = 1'b0;
            instr_ready = 1'b1;
            npc         = 32'h0000_3008 + 4 * i;
            step();
        end
        chk("seq_ret", {29'b0, retired}, 32'h4);
        chk("seq_pc", pc, 32'h0000_3010);

        instr_ready = 1'b0;
        imem_rdata  = 32'hCAFE_0005;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("dly_req", {31'b0, imem_req}, 32'h1);
            chk("dly_addr", imem_addr, 32'h0000_3010);
        end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        chk("dly_valid", {31'b0, instr_valid}, 32'h1);
        chk("dly_instr", instr, 32'hCAFE_0005);

        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            npc = i[0] ? 32'h0000_4000 : 32'h0000_5002;
            step();
        end
        imem_ack = 1'b0;
        chk("stl_pc", pc, 32'h0000_3010);
        chk("stl_instr", instr, 32'hCAFE_0005);
        chk("stl_ret", {29'b0, retired}, 32'h4);

        instr_ready = 1'b1;
        npc         = 32'h0000_3006;
        step();
        chk("err_flag", {31'b0, addr_err}, 32'h1);
        chk("err_pc", pc, 32'h0000_3006);
        chk("err_valid", {31'b0, instr_valid}, 32'h0);
        chk("err_req", {31'b0, imem_req}, 32'h0);
        imem_ack = 1'b1;
        npc      = 32'h0000_3100;
        step();
        step();
        chk("err_hold", pc, 32'h0000_3006);
        chk("err_ret", {29'b0, retired}, 32'h5);

        #3 reset = 1'b0;
        #1;
        chk("err_rst_pc", pc, 32'h0000_3000);
        chk("err_rst_flag", {31'b0, addr_err}, 32'h0);
        instr_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("mid_req", {31'b0, imem_req}, 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("mid_drop", {31'b0, imem_req}, 32'h0);
        step();
        reset = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            imem_ack    = 1'b1;
            instr_ready = 1'b0;
            imem_rdata  = 32'h5000_0000 + i;
            step();
            imem_ack    = 1'b0;
            instr_ready = 1'b1;
            npc         = (i == 0) ? 32'h0000_3000 : 32'h0000_3000 + 4 * i;
            step();
            if (i == 0) chk("self_addr", imem_addr, 32'h0000_3000);
        end
        chk("wrap_ret", {29'b0, retired}, 32'h0);
        chk("wrap_pc", pc, 32'h0000_301C);

        instr_ready = 1'b0;
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
